// File: rtl/wb_register_slice_if.sv
// wb_register_slice_if
//   One Wishbone classic link (request + response fields).
//   The slice takes the upstream link on its `slave` modport and drives the
//   downstream (target-side) link on its `master` modport.
//
// Handshake: the request is valid while cyc & stb are high; the initiator holds
// adr/dat_w/sel/we stable until the target answers with a one-cycle ack or err
// (or until the initiator drops cyc to abandon the cycle).
//
// Signals:
//   adr    [ADDR_WIDTH]   address             (initiator -> target)
//   dat_w  [DATA_WIDTH]   write data          (initiator -> target)
//   sel    [DATA_WIDTH/8] byte selects        (initiator -> target)
//   we, cyc, stb          write / cycle / strobe (initiator -> target)
//   dat_r  [DATA_WIDTH]   read data           (target -> initiator)
//   ack, err              response            (target -> initiator)
interface wb_register_slice_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_register_slice.sv
// wb_register_slice
//   Single-outstanding Wishbone classic register slice with a bus-timeout
//   watchdog. Request and response paths are fully registered, so no
//   combinational path crosses the slice. A target that never answers is
//   turned into an upstream err instead of hanging the bus.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      synchronous, active-high
//   up         upstream link (slave side: adr/dat_w/sel/we/cyc/stb in,
//              dat_r/ack/err out)
//   t          downstream link (master side: t.adr/t.dat_w/t.sel/t.we/t.cyc/
//              t.stb out, t.dat_r/t.ack/t.err in)
//   state_dbg  current FSM state (0 IDLE, 1 REQ, 2 RSP)
//
// Handshake: an upstream request is accepted when cyc & stb are sampled high
// in IDLE. The slice then holds one strobe downstream until the target answers
// (ack/err), the initiator drops cyc (abort, no response), or the watchdog
// fires. The upstream response (ack or err) is a single-cycle pulse.
module wb_register_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  wb_register_slice_if.slave         up,
  wb_register_slice_if.master        t,
  output logic [1:0]                 state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT != 0);

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;

  assign state_dbg = state;

  // wd_cnt counts REQ cycles already spent waiting; the watchdog fires in the
  // REQ cycle where TIMEOUT cycles have passed with no answer, so the upstream
  // err appears TIMEOUT+1 cycles after t.stb first rises.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wd_cnt   <= '0;
      t.adr    <= '0;
      t.dat_w  <= '0;
      t.sel    <= '0;
      t.we     <= 1'b0;
      t.cyc    <= 1'b0;
      t.stb    <= 1'b0;
      up.dat_r <= '0;
      up.ack   <= 1'b0;
      up.err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (up.cyc && up.stb) begin
            t.adr   <= up.adr;
            t.dat_w <= up.dat_w;
            t.sel   <= up.sel;
            t.we    <= up.we;
            t.cyc   <= 1'b1;
            t.stb   <= 1'b1;
            wd_cnt  <= '0;
            state   <= REQ;
          end
        end

        REQ: begin
          if (!up.cyc) begin
            // Abort: the initiator gave up; any same-cycle target answer is lost.
            t.cyc <= 1'b0;
            t.stb <= 1'b0;
            state <= IDLE;
          end else if (t.err) begin
            // err takes precedence over a simultaneous ack.
            up.dat_r <= t.dat_r;
            up.err   <= 1'b1;
            t.cyc    <= 1'b0;
            t.stb    <= 1'b0;
            state    <= RSP;
          end else if (t.ack) begin
            // Writes capture too; the initiator ignores dat_r on a write.
            up.dat_r <= t.dat_r;
            up.ack   <= 1'b1;
            t.cyc    <= 1'b0;
            t.stb    <= 1'b0;
            state    <= RSP;
          end else if (WD_EN && (wd_cnt == CNT_LIMIT)) begin
            up.dat_r <= '0;
            up.err   <= 1'b1;
            t.cyc    <= 1'b0;
            t.stb    <= 1'b0;
            state    <= RSP;
          end else if (wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        RSP: begin
          // Response pulse lasts one cycle; cyc is not examined here.
          up.ack <= 1'b0;
          up.err <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          up.ack <= 1'b0;
          up.err <= 1'b0;
          t.cyc  <= 1'b0;
          t.stb  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_register_slice.sv
module tb_wb_register_slice;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;

  wb_register_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_if ();
  wb_register_slice_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) t_if ();

  wb_register_slice #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .up       (up_if),
    .t        (t_if),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    up_if.cyc = 1'b0; up_if.stb = 1'b0; up_if.we = 1'b0;
    up_if.adr = '0; up_if.dat_w = '0; up_if.sel = '0;
    t_if.ack = 1'b0; t_if.err = 1'b0; t_if.dat_r = '0;
  endtask

  // One upstream transaction issued in cycle 0. The target answers in the
  // (wait_n+1)-th cycle it sees t.stb high with the chosen ack/err.
  // rsp_cycle is the cycle in which upstream ack/err is seen (-1 if none).
  task automatic do_txn(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  int          wait_n,
    input  logic [31:0] rdata,
    input  logic        give_ack,
    input  logic        give_err,
    output int          stb_cycles,
    output int          rsp_cycle,
    output logic        r_ack,
    output logic        r_err,
    output logic        r_tcyc,
    output logic        r_after,
    output logic [31:0] r_dat
  );
    stb_cycles = 0; rsp_cycle = -1;
    r_ack = 1'b0; r_err = 1'b0; r_tcyc = 1'b1; r_after = 1'b1; r_dat = '0;
    up_if.we = w; up_if.adr = a; up_if.dat_w = d; up_if.sel = s;
    up_if.cyc = 1'b1; up_if.stb = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      t_if.ack = 1'b0; t_if.err = 1'b0;
      if (up_if.ack || up_if.err) begin
        rsp_cycle = c;
        r_ack  = up_if.ack;
        r_err  = up_if.err;
        r_dat  = up_if.dat_r;
        r_tcyc = t_if.cyc;
        up_if.cyc = 1'b0; up_if.stb = 1'b0;
        break;
      end
      if (t_if.stb) begin
        stb_cycles++;
        if (stb_cycles == wait_n + 1) begin
          t_if.ack   = give_ack;
          t_if.err   = give_err;
          t_if.dat_r = rdata;
        end
      end
    end
    up_if.cyc = 1'b0; up_if.stb = 1'b0;
    step();
    r_after = up_if.ack | up_if.err;
  endtask

  int          stb_n, rsp_c;
  logic        g_ack, g_err, g_tcyc, g_after;
  logic [31:0] g_dat;
  int          ack_cycles[$];
  logic        seen_rsp;
  logic [31:0] rd_val;

  initial begin
    idle_bus();
    reset = 1'b1;
    repeat (3) step();

    // ---- reset state ----
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_t_cyc", 32'(t_if.cyc), 32'd0);
    check("rst_ack",   32'(up_if.ack | up_if.err), 32'd0);
    check("rst_dat_r", up_if.dat_r, 32'h0);
    reset = 1'b0;
    step();

    // ---- write, zero wait ----
    do_txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b1, 1'b0,
           stb_n, rsp_c, g_ack, g_err, g_tcyc, g_after, g_dat);
    check("wr_rsp_cycle", 32'(rsp_c), 32'd2);
    check("wr_ack",       32'(g_ack), 32'd1);
    check("wr_err",       32'(g_err), 32'd0);
    check("wr_stb_cycles", 32'(stb_n), 32'd1);
    check("wr_ack_one_cycle", 32'(g_after), 32'd0);
    check("wr_t_adr",   t_if.adr,   32'h1000_0004);
    check("wr_t_dat_w", t_if.dat_w, 32'hDEAD_BEEF);
    check("wr_t_sel",   32'(t_if.sel), 32'hF);
    check("wr_t_we",    32'(t_if.we),  32'd1);

    // ---- read, 5 wait states ----
    do_txn(1'b0, 32'h2000_0010, 32'h0, 4'hF, 5, 32'h1234_5678, 1'b1, 1'b0,
           stb_n, rsp_c, g_ack, g_err, g_tcyc, g_after, g_dat);
    check("rd5_rsp_cycle",  32'(rsp_c), 32'd7);
    check("rd5_ack",        32'(g_ack), 32'd1);
    check("rd5_dat_r",      g_dat, 32'h1234_5678);
    check("rd5_stb_cycles", 32'(stb_n), 32'd6);
    check("rd5_t_we",       32'(t_if.we), 32'd0);

    // ---- err together with ack ----
    do_txn(1'b0, 32'h3000_0000, 32'h0, 4'h3, 2, 32'hBADC_0DE5, 1'b1, 1'b1,
           stb_n, rsp_c, g_ack, g_err, g_tcyc, g_after, g_dat);
    check("errack_rsp_cycle", 32'(rsp_c), 32'd4);
    check("errack_err",   32'(g_err), 32'd1);
    check("errack_ack",   32'(g_ack), 32'd0);
    check("errack_dat_r", g_dat, 32'hBADC_0DE5);
    check("errack_one_cycle", 32'(g_after), 32'd0);

    // ---- timeout with silent target (TIMEOUT = 16) ----
    do_txn(1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0,
           stb_n, rsp_c, g_ack, g_err, g_tcyc, g_after, g_dat);
    check("to_rsp_cycle",  32'(rsp_c), 32'd18);
    check("to_err",        32'(g_err), 32'd1);
    check("to_ack",        32'(g_ack), 32'd0);
    check("to_dat_r",      g_dat, 32'h0);
    check("to_t_cyc_low",  32'(g_tcyc), 32'd0);
    check("to_stb_cycles", 32'(stb_n), 32'd17);
    check("to_one_cycle",  32'(g_after), 32'd0);

    // follow-up read to a responsive target
    do_txn(1'b0, 32'h4000_0004, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 1'b1, 1'b0,
           stb_n, rsp_c, g_ack, g_err, g_tcyc, g_after, g_dat);
    check("to_follow_rsp_cycle", 32'(rsp_c), 32'd3);
    check("to_follow_ack",       32'(g_ack), 32'd1);
    check("to_follow_dat_r",     g_dat, 32'hCAFE_F00D);

    // ---- abort: cyc dropped at cycle 3, late t_ack at cycle 4 ----
    up_if.we = 1'b0; up_if.adr = 32'h5000_0000; up_if.sel = 4'hF;
    up_if.cyc = 1'b1; up_if.stb = 1'b1;
    step(); step(); step();                 // now in cycle 3
    check("abort_t_cyc_c3", 32'(t_if.cyc), 32'd1);
    up_if.cyc = 1'b0; up_if.stb = 1'b0;
    step();                                 // cycle 4
    check("abort_t_cyc_c4", 32'(t_if.cyc), 32'd0);
    check("abort_t_stb_c4", 32'(t_if.stb), 32'd0);
    t_if.ack = 1'b1; t_if.dat_r = 32'h5555_5555;
    seen_rsp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      t_if.ack = 1'b0;
      if (up_if.ack || up_if.err) seen_rsp = 1'b1;
    end
    check("abort_no_rsp", 32'(seen_rsp), 32'd0);
    check("abort_state_idle", 32'(state_dbg), 32'd0);
    check("abort_dat_r_kept", up_if.dat_r, 32'hCAFE_F00D);

    // ---- reset mid-REQ ----
    up_if.we = 1'b1; up_if.adr = 32'h6000_0008; up_if.dat_w = 32'h0BAD_F00D;
    up_if.sel = 4'h5; up_if.cyc = 1'b1; up_if.stb = 1'b1;
    step(); step();
    check("rreq_in_req", 32'(state_dbg), 32'd1);
    reset = 1'b1;
    up_if.cyc = 1'b0; up_if.stb = 1'b0;
    step();
    check("rreq_t_cyc",   32'(t_if.cyc), 32'd0);
    check("rreq_t_stb",   32'(t_if.stb), 32'd0);
    check("rreq_t_adr",   t_if.adr, 32'h0);
    check("rreq_t_dat_w", t_if.dat_w, 32'h0);
    check("rreq_t_sel",   32'(t_if.sel), 32'h0);
    check("rreq_t_we",    32'(t_if.we), 32'd0);
    check("rreq_ack_err", 32'({up_if.ack, up_if.err}), 32'd0);
    check("rreq_dat_r",   up_if.dat_r, 32'h0);
    check("rreq_state",   32'(state_dbg), 32'd0);
    reset = 1'b0;
    step();

    // ---- back-to-back reads with cyc/stb held high ----
    exp_q.push_back(32'h1111_0001);
    exp_q.push_back(32'h2222_0002);
    rd_val = 32'h1111_0001;
    up_if.we = 1'b0; up_if.adr = 32'h7000_0000; up_if.sel = 4'hF;
    up_if.cyc = 1'b1; up_if.stb = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      t_if.ack = 1'b0;
      if (up_if.ack) begin
        ack_cycles.push_back(c);
        if (exp_q.size() > 0) check("b2b_dat_r", up_if.dat_r, exp_q.pop_front());
        if (ack_cycles.size() == 2) begin
          up_if.cyc = 1'b0; up_if.stb = 1'b0;
          break;
        end
        rd_val = 32'h2222_0002;
      end
      if (t_if.stb) begin
        t_if.ack = 1'b1;
        t_if.dat_r = rd_val;
      end
    end
    up_if.cyc = 1'b0; up_if.stb = 1'b0; t_if.ack = 1'b0;
    check("b2b_ack_count", 32'(ack_cycles.size()), 32'd2);
    if (ack_cycles.size() == 2) begin
      check("b2b_first_ack", 32'(ack_cycles[0]), 32'd2);
      check("b2b_spacing", 32'(ack_cycles[1] - ack_cycles[0]), 32'd3);
    end
    check("b2b_exp_q_drained", 32'(exp_q.size()), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
